// File: rtl/k6502_seq_pkg.sv
// Shared definitions for the k6502 instruction sequencer: one-hot microcycle
// constants, the BRK opcode forced into IR on interrupt entry, and the
// pend-select encoding presented to the microcode decoder.
package k6502_defs;

  localparam int CYC_W = 6;

  localparam logic [CYC_W-1:0] C_N = 6'b000000;
  localparam logic [CYC_W-1:0] C_0 = 6'b000001;
  localparam logic [CYC_W-1:0] C_1 = 6'b000010;
  localparam logic [CYC_W-1:0] C_2 = 6'b000100;
  localparam logic [CYC_W-1:0] C_3 = 6'b001000;
  localparam logic [CYC_W-1:0] C_4 = 6'b010000;
  localparam logic [CYC_W-1:0] C_5 = 6'b100000;

  localparam logic [7:0] IR_BRK = 8'h00;

  // Bit positions line up with the {rst, nmi, irq} select of the microcode.
  typedef enum logic [2:0] {
    PEND_NON = 3'b000,
    PEND_IRQ = 3'b001,
    PEND_NMI = 3'b010,
    PEND_RST = 3'b100
  } pend_e;

  // The final legal microcycle; stepping past it is a microcode overrun.
  function automatic logic cyc_is_last(input logic [CYC_W-1:0] cyc);
    return cyc == C_5;
  endfunction

endpackage

// File: rtl/k6502_seq_nmi_edge.sv
// NMI falling-edge detector with a request latch. The pin is sampled every
// clock regardless of stalls so no edge is lost; the request is held until a
// boundary accepts it. An edge in the same cycle as the accepting boundary is
// consumed by that boundary rather than re-latched.
module k6502_nmi_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi_n,
  input  logic take,
  output logic nmi_edge,
  output logic nmi_req
);

  logic nmi_q;
  logic nmi_d;
  logic nmi_req_q;
  logic nmi_req_d;

  // Edge detect and request set/clear.
  always_comb begin
    nmi_edge  = nmi_q & ~nmi_n;
    nmi_d     = nmi_n;
    nmi_req_d = nmi_req_q;
    if (take) begin
      nmi_req_d = 1'b0;
    end else if (nmi_edge) begin
      nmi_req_d = 1'b1;
    end
  end

  // Pin sample and request latch; reset treats the pin as idle-high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nmi_q     <= 1'b1;
      nmi_req_q <= 1'b0;
    end else begin
      nmi_q     <= nmi_d;
      nmi_req_q <= nmi_req_d;
    end
  end

  assign nmi_req = nmi_req_q;

endmodule

// File: rtl/k6502_seq.sv
// k6502 instruction sequencer. Steps the one-hot microcycle, latches the next
// opcode at instruction boundaries and arbitrates RST/NMI/IRQ entry there.
// A sequence that runs past C_5 is forced to a boundary and flagged sticky.
module k6502_seq #(
  parameter int CYC_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic [7:0]       data_in,
  input  logic             sync_next,
  input  logic             i_flag,
  input  logic             nmi_n,
  input  logic             irq_n,
  output logic [7:0]       ir,
  output logic [CYC_W-1:0] cycle,
  output logic             rst_pend,
  output logic             nmi_pend,
  output logic             irq_pend,
  output logic             instr_start,
  output logic             ucode_err
);

  import k6502_defs::*;

  logic [CYC_W-1:0] cycle_q;
  logic [CYC_W-1:0] cycle_d;
  logic [7:0]       ir_q;
  logic [7:0]       ir_d;
  pend_e            pend_q;
  pend_e            pend_d;
  logic             instr_start_q;
  logic             instr_start_d;
  logic             ucode_err_q;
  logic             ucode_err_d;

  logic             nmi_edge;
  logic             nmi_req;
  logic             nmi_take;
  logic             nmi_sel;
  logic             irq_sel;
  logic             boundary;
  logic             overrun;

  k6502_nmi_edge u_nmi_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .nmi_n    (nmi_n),
    .take     (nmi_take),
    .nmi_edge (nmi_edge),
    .nmi_req  (nmi_req)
  );

  // Boundary detection: normal end via SYNC-NEXT or forced end after C_5.
  // Nothing advances while stalled, and C_N is never a boundary.
  always_comb begin
    boundary = 1'b0;
    overrun  = 1'b0;
    if (rdy && (cycle_q != C_N)) begin
      if (sync_next) begin
        boundary = 1'b1;
      end else if (cyc_is_last(cycle_q)) begin
        boundary = 1'b1;
        overrun  = 1'b1;
      end
    end
    nmi_sel  = nmi_req | nmi_edge;
    irq_sel  = ~irq_n & ~i_flag;
    nmi_take = boundary & nmi_sel;
  end

  // Cycle shifter: C_N enters C_0 on the first ready edge, boundaries
  // restart at C_0, otherwise shift one position left.
  always_comb begin
    cycle_d       = cycle_q;
    instr_start_d = 1'b0;
    ucode_err_d   = ucode_err_q | overrun;
    if (rdy) begin
      if (cycle_q == C_N) begin
        cycle_d = C_0;
      end else if (boundary) begin
        cycle_d       = C_0;
        instr_start_d = 1'b1;
      end else begin
        cycle_d = cycle_q << 1;
      end
    end
  end

  // IR register: interrupt entry substitutes BRK, a fetch takes the bus.
  always_comb begin
    ir_d = ir_q;
    if (boundary) begin
      if (nmi_sel || irq_sel) begin
        ir_d = IR_BRK;
      end else begin
        ir_d = data_in;
      end
    end
  end

  // Pend arbiter: at a boundary the old sequence ends and NMI beats IRQ
  // beats a plain fetch. Exactly one or none of the flags is ever set.
  always_comb begin
    pend_d = pend_q;
    if (boundary) begin
      if (nmi_sel) begin
        pend_d = PEND_NMI;
      end else if (irq_sel) begin
        pend_d = PEND_IRQ;
      end else begin
        pend_d = PEND_NON;
      end
    end
  end

  // Sequencer state; reset aborts any sequence and starts the reset one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q       <= C_N;
      ir_q          <= IR_BRK;
      pend_q        <= PEND_RST;
      instr_start_q <= 1'b0;
      ucode_err_q   <= 1'b0;
    end else begin
      cycle_q       <= cycle_d;
      ir_q          <= ir_d;
      pend_q        <= pend_d;
      instr_start_q <= instr_start_d;
      ucode_err_q   <= ucode_err_d;
    end
  end

  assign ir          = ir_q;
  assign cycle       = cycle_q;
  assign rst_pend    = pend_q[2];
  assign nmi_pend    = pend_q[1];
  assign irq_pend    = pend_q[0];
  assign instr_start = instr_start_q;
  assign ucode_err   = ucode_err_q;

endmodule

// File: tb/tb_k6502_seq.sv
// Bench for k6502_seq: directed scenarios against fixed expectations, then a
// randomized run checked cycle by cycle against a behavioural model.
module tb_k6502_seq;

  logic       clk;
  logic       rst_n;
  logic       rdy;
  logic [7:0] data_in;
  logic       sync_next;
  logic       i_flag;
  logic       nmi_n;
  logic       irq_n;
  logic [7:0] ir;
  logic [5:0] cycle;
  logic       rst_pend;
  logic       nmi_pend;
  logic       irq_pend;
  logic       instr_start;
  logic       ucode_err;

  int errors = 0;
  int checks = 0;

  // Behavioural model: cycle as an index (-1 = idle), pend as a kind code.
  localparam int K_NON = 0, K_RST = 1, K_NMI = 2, K_IRQ = 3;
  int         m_cyc     = -1;
  logic [7:0] m_ir      = 8'h00;
  int         m_kind    = K_RST;
  logic       m_err     = 1'b0;
  logic       m_start   = 1'b0;
  logic       m_pin_old = 1'b1;
  logic       m_req     = 1'b0;

  k6502_seq #(.CYC_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .data_in     (data_in),
    .sync_next   (sync_next),
    .i_flag      (i_flag),
    .nmi_n       (nmi_n),
    .irq_n       (irq_n),
    .ir          (ir),
    .cycle       (cycle),
    .rst_pend    (rst_pend),
    .nmi_pend    (nmi_pend),
    .irq_pend    (irq_pend),
    .instr_start (instr_start),
    .ucode_err   (ucode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance the model by one clock using the inputs the DUT sees.
  task automatic model_update();
    logic fell;
    if (!rst_n) begin
      m_cyc = -1; m_ir = 8'h00; m_kind = K_RST; m_err = 1'b0;
      m_start = 1'b0; m_pin_old = 1'b1; m_req = 1'b0;
    end else begin
      fell = m_pin_old && !nmi_n;
      m_pin_old = nmi_n;
      m_start = 1'b0;
      if (rdy) begin
        if (m_cyc < 0) begin
          m_cyc = 0;
        end else if (sync_next || m_cyc == 5) begin
          if (!sync_next) m_err = 1'b1;
          m_cyc = 0;
          m_start = 1'b1;
          if (m_req || fell) begin
            m_kind = K_NMI; m_ir = 8'h00; m_req = 1'b0; fell = 1'b0;
          end else if (!irq_n && !i_flag) begin
            m_kind = K_IRQ; m_ir = 8'h00;
          end else begin
            m_kind = K_NON; m_ir = data_in;
          end
        end else begin
          m_cyc = m_cyc + 1;
        end
      end
      if (fell) m_req = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [5:0] onehot(input int idx);
    if (idx < 0) return 6'd0;
    return 6'd1 << idx;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; sync_next = 1'b0; data_in = 8'hFF;
    i_flag = 1'b1; nmi_n = 1'b1; irq_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cycle !== 6'b000000) begin errors++; $display("FAIL reset_cycle got=%b exp=%b", cycle, 6'b000000); end
      checks++; if (ir !== 8'h00) begin errors++; $display("FAIL reset_ir got=%h exp=00", ir); end
      checks++; if ({rst_pend, nmi_pend, irq_pend} !== 3'b100) begin errors++; $display("FAIL reset_pend got=%b exp=100", {rst_pend, nmi_pend, irq_pend}); end
      checks++; if (instr_start !== 1'b0 || ucode_err !== 1'b0) begin errors++; $display("FAIL reset_start_err got=%b%b exp=00", instr_start, ucode_err); end
    end
  endtask

  task automatic test_reset_seq();
    int starts;
    starts = 0;
    rst_n = 1'b1; sync_next = 1'b0;
    tick();
    checks++; if (cycle !== 6'b000001) begin errors++; $display("FAIL rstseq_first_c0 got=%b exp=000001", cycle); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (instr_start) starts++;
      checks++; if (cycle !== onehot(k) || rst_pend !== 1'b1) begin errors++; $display("FAIL rstseq_c%0d got=%b rst=%b exp=%b rst=1", k, cycle, rst_pend, onehot(k)); end
    end
    sync_next = 1'b1; data_in = 8'hA9;
    tick();
    if (instr_start) starts++;
    checks++; if (cycle !== 6'b000001 || ir !== 8'hA9) begin errors++; $display("FAIL rstseq_boundary got=%b/%h exp=000001/a9", cycle, ir); end
    checks++; if ({rst_pend, nmi_pend, irq_pend} !== 3'b000) begin errors++; $display("FAIL rstseq_pend got=%b exp=000", {rst_pend, nmi_pend, irq_pend}); end
    sync_next = 1'b0;
    tick();
    if (instr_start) starts++;
    checks++; if (starts != 1) begin errors++; $display("FAIL rstseq_start_pulses got=%0d exp=1", starts); end
  endtask

  task automatic test_two_cycle();
    // Currently in C_1 of A9.
    sync_next = 1'b1; data_in = 8'hEA;
    tick();
    checks++; if (cycle !== 6'b000001 || ir !== 8'hEA || instr_start !== 1'b1) begin errors++; $display("FAIL two_cycle got=%b/%h/%b exp=000001/ea/1", cycle, ir, instr_start); end
  endtask

  task automatic test_nmi_stall();
    sync_next = 1'b0;
    tick();
    rdy = 1'b0; sync_next = 1'b1; irq_n = 1'b0; i_flag = 1'b0; nmi_n = 1'b0; data_in = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cycle !== 6'b000010 || ir !== 8'hEA || instr_start !== 1'b0 || {rst_pend, nmi_pend, irq_pend} !== 3'b000) begin errors++; $display("FAIL stall_hold got=%b/%h/%b/%b", cycle, ir, instr_start, {rst_pend, nmi_pend, irq_pend}); end
    end
    rdy = 1'b1;
    tick();
    checks++; if (nmi_pend !== 1'b1 || irq_pend !== 1'b0 || ir !== 8'h00 || cycle !== 6'b000001) begin errors++; $display("FAIL nmi_priority got=n%b i%b ir=%h cyc=%b exp=n1 i0 ir=00 cyc=000001", nmi_pend, irq_pend, ir, cycle); end
    sync_next = 1'b0;
    tick();
    sync_next = 1'b1;
    tick();
    checks++; if (irq_pend !== 1'b1 || nmi_pend !== 1'b0 || ir !== 8'h00) begin errors++; $display("FAIL irq_after_nmi got=i%b n%b ir=%h exp=i1 n0 ir=00", irq_pend, nmi_pend, ir); end
  endtask

  task automatic test_masked_irq();
    sync_next = 1'b0;
    tick();
    i_flag = 1'b1; irq_n = 1'b0; sync_next = 1'b1; data_in = 8'h18;
    tick();
    checks++; if (ir !== 8'h18 || irq_pend !== 1'b0) begin errors++; $display("FAIL masked_irq got=ir %h irq %b exp=ir 18 irq 0", ir, irq_pend); end
  endtask

  task automatic test_undef();
    irq_n = 1'b1; sync_next = 1'b0;
    tick();
    sync_next = 1'b1; data_in = 8'h02;
    tick();
    sync_next = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (cycle !== onehot(k) || ucode_err !== 1'b0) begin errors++; $display("FAIL undef_walk_c%0d got=%b err=%b exp=%b err=0", k, cycle, ucode_err, onehot(k)); end
    end
    data_in = 8'h77;
    tick();
    checks++; if (cycle !== 6'b000001 || ir !== 8'h77 || ucode_err !== 1'b1 || instr_start !== 1'b1) begin errors++; $display("FAIL undef_overrun got=%b/%h/%b/%b exp=000001/77/1/1", cycle, ir, ucode_err, instr_start); end
    for (int i = 0; i < 4; i++) begin
      sync_next = 1'($urandom_range(0, 1)); rdy = 1'($urandom_range(0, 1)); data_in = 8'($urandom);
      tick();
      checks++; if (ucode_err !== 1'b1) begin errors++; $display("FAIL undef_sticky got=%b exp=1", ucode_err); end
    end
    rdy = 1'b1;
  endtask

  task automatic test_reset_mid();
    sync_next = 1'b1; data_in = 8'hAD; nmi_n = 1'b1; irq_n = 1'b1;
    tick();
    sync_next = 1'b0; nmi_n = 1'b0;
    tick();
    tick();
    checks++; if (cycle !== 6'b000100 || ir !== 8'hAD) begin errors++; $display("FAIL rstmid_setup got=%b/%h exp=000100/ad", cycle, ir); end
    rst_n = 1'b0; nmi_n = 1'b1;
    tick();
    checks++; if (cycle !== 6'b000000 || ir !== 8'h00 || rst_pend !== 1'b1 || ucode_err !== 1'b0) begin errors++; $display("FAIL rstmid_abort got=%b/%h/%b/%b exp=000000/00/1/0", cycle, ir, rst_pend, ucode_err); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    sync_next = 1'b1; data_in = 8'h3C;
    tick();
    checks++; if (nmi_pend !== 1'b0 || ir !== 8'h3C) begin errors++; $display("FAIL rstmid_nmi_cleared got=nmi %b ir %h exp=nmi 0 ir 3c", nmi_pend, ir); end
  endtask

  task automatic test_random();
    rst_n = 1'b0;
    tick();
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      rdy       = ($urandom_range(0, 4) != 0);
      sync_next = ($urandom_range(0, 3) == 0);
      data_in   = 8'($urandom);
      i_flag    = 1'($urandom_range(0, 1));
      irq_n     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) nmi_n = ~nmi_n;
      tick();
      checks++; if (cycle !== onehot(m_cyc)) begin errors++; $display("FAIL rand_cycle n=%0d got=%b exp=%b", n, cycle, onehot(m_cyc)); end
      checks++; if (ir !== m_ir) begin errors++; $display("FAIL rand_ir n=%0d got=%h exp=%h", n, ir, m_ir); end
      checks++; if ({rst_pend, nmi_pend, irq_pend} !== {m_kind == K_RST, m_kind == K_NMI, m_kind == K_IRQ}) begin errors++; $display("FAIL rand_pend n=%0d got=%b kind=%0d", n, {rst_pend, nmi_pend, irq_pend}, m_kind); end
      checks++; if (instr_start !== m_start) begin errors++; $display("FAIL rand_start n=%0d got=%b exp=%b", n, instr_start, m_start); end
      checks++; if (ucode_err !== m_err) begin errors++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, ucode_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_seq();
    test_two_cycle();
    test_nmi_stall();
    test_masked_irq();
    test_undef();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
